wdt_reg_sync_rx: RTL and testbench
==================================

// Module: wdt_reg_sync_rx
// PURPOSE
//  Receive side of the watchdog register-write CDC bridge, in the clk2 domain.
//  Takes toggle-handshake write requests from the CPU/bus domain (clk) and converts them
//  into the value + single-cycle *_RVALID strobes consumed by the watchdog timer.
//  Returns an ack toggle to the bus domain. Sits directly upstream of the watchdog.
// PARAMETERS
//  SYNC_STAGES  2       flops in the req-toggle synchroniser (>=2)
//  ADDR_W       16      width of src_addr_i
//  ADDR_WDEN    16'h0100  write address of WDEN (data bit 0)
//  ADDR_WDLIVE  16'h0200  write address of WDLIVE (data bit 0)
//  ADDR_WTOCNT  16'h0300  write address of WTOCNT (data bits 31:0)
// PORTS
//  clk2           in   1       watchdog clock
//  rst2           in   1       reset, asynchronous, active-high
//  src_req_tog_i  in   1       request toggle from clk domain (asynchronous)
//  src_addr_i     in   ADDR_W  write address; source holds stable from toggle until ack seen
//  src_wdata_i    in   32      write data; held stable like src_addr_i
//  dst_ack_tog_o  out  1       ack toggle back to clk domain (registered, clk2)
//  WDEN           out  1       watchdog enable value
//  WDLIVE         out  1       watchdog kick value
//  WTOCNT         out  32      watchdog timeout threshold
//  WDEN_RVALID    out  1       1-cycle strobe: WDEN updated
//  WDLIVE_RVALID  out  1       1-cycle strobe: WDLIVE updated
//  WTOCNT_RVALID  out  1       1-cycle strobe: WTOCNT updated
//  bad_addr_o     out  1       sticky: a request hit an undecoded address
// BEHAVIOUR
//  - Reset: all outputs 0, sync chain 0, req_seen 0, state IDLE. Reset mid-transaction
//    aborts it: no strobe after rst2 deasserts, ack not toggled; bus side is reset together.
//  - Only src_req_tog_i is synchronised (SYNC_STAGES flops). addr/data are sampled
//    directly and are stable by protocol. new_req = sync_out ^ req_seen.
//  - FSM, all outputs registered:
//    IDLE : on new_req -> req_seen<=sync_out; decode src_addr_i (exact match on ADDR_W bits);
//           update the matching value reg from src_wdata_i and set its RVALID; no match ->
//           no value/RVALID change, bad_addr_o<=1. Go ISSUE.
//    ISSUE: RVALIDs high for exactly this cycle; at next edge clear all RVALIDs,
//           dst_ack_tog_o<=~dst_ack_tog_o, go ACK.
//    ACK  : one idle cycle, go IDLE (min 3 clk2 cycles between accepted requests).
//  - Value + RVALID change on the same edge, so the value is valid whenever its RVALID is high.
//  - At most one RVALID asserted per request; at most one request in flight.
//  - Value regs hold last written value between writes (WDLIVE included; not auto-cleared).
//  - Latency: toggle edge -> RVALID high = SYNC_STAGES+1 clk2 edges (up to +1 for metastability);
//    RVALID high -> ack toggle = 1 edge.
//  - Toggle changing again before ack (protocol violation): new_req is not evaluated outside
//    IDLE; req_seen tracks sync_out only in IDLE, so an even number of toggles is lost and an
//    odd number is one request.
//  - bad_addr_o clears only on rst2. Undecoded requests are still acked.
//  - WTOCNT write takes all 32 bits; WDEN/WDLIVE take bit 0, bits 31:1 ignored.
// TESTING
//  1 Reset: rst2=1 with req toggling -> all outputs 0, no strobes, ack stays 0.
//  2 Write addr 0x0300 data 0xDEAD_BEEF, toggle req -> WTOCNT=0xDEADBEEF, WTOCNT_RVALID
//    high 1 cycle at edge SYNC_STAGES+1, other strobes 0, ack toggles 1 edge later.
//  3 Write 0x0100 data 0x1, then 0x0200 data 0x3 -> WDEN=1 + strobe, then WDLIVE=1 + strobe;
//    WDEN still 1 after second write; 2 ack toggles total.
//  4 Write addr 0x0104 -> no RVALID, values unchanged, bad_addr_o=1 and stays 1, ack toggles.
//  5 rst2 pulse while in ISSUE -> RVALID drops immediately, ack not toggled, next req works.
//  6 Double toggle within 1 cycle in IDLE (glitch pair) -> no request taken, no ack.

Source files
------------

// File: rtl/wdt_reg_sync_rx.sv
// Watchdog register-write CDC receiver (clk2 domain): turns the bus-side request toggle into
// watchdog value updates with one-cycle RVALID strobes, and returns an ack toggle.
//
// state | meaning
// IDLE  | waiting for a new request toggle; decodes and captures on arrival
// ISSUE | RVALID strobe high this cycle; ack toggles at the next edge
// ACK   | one idle cycle before another request may be taken
module wdt_reg_sync_rx #(
  parameter int unsigned              SYNC_STAGES = 2,
  parameter int unsigned              ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]        ADDR_WDEN   = 16'h0100,
  parameter logic [ADDR_W-1:0]        ADDR_WDLIVE = 16'h0200,
  parameter logic [ADDR_W-1:0]        ADDR_WTOCNT = 16'h0300
) (
  input  logic              clk2,
  input  logic              rst2,
  input  logic              src_req_tog_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [31:0]       src_wdata_i,
  output logic              dst_ack_tog_o,
  output logic              WDEN,
  output logic              WDLIVE,
  output logic [31:0]       WTOCNT,
  output logic              WDEN_RVALID,
  output logic              WDLIVE_RVALID,
  output logic              WTOCNT_RVALID,
  output logic              bad_addr_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACK} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_seen_q, req_seen_d;
  logic                   wden_q, wden_d;
  logic                   wdlive_q, wdlive_d;
  logic [31:0]            wtocnt_q, wtocnt_d;
  logic [2:0]             rvalid_q, rvalid_d;   // {wden, wdlive, wtocnt}
  logic                   ack_q, ack_d;
  logic                   bad_q, bad_d;

  logic sync_out;
  logic new_req;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign new_req  = sync_out ^ req_seen_q;

  always_ff @(posedge clk2 or posedge rst2) begin
    if (rst2) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      req_seen_q <= 1'b0;
      wden_q     <= 1'b0;
      wdlive_q   <= 1'b0;
      wtocnt_q   <= '0;
      rvalid_q   <= '0;
      ack_q      <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], src_req_tog_i};
      req_seen_q <= req_seen_d;
      wden_q     <= wden_d;
      wdlive_q   <= wdlive_d;
      wtocnt_q   <= wtocnt_d;
      rvalid_q   <= rvalid_d;
      ack_q      <= ack_d;
      bad_q      <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (new_req) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Strobes default low, so they are high only in the cycle after capture.
  always_comb begin
    req_seen_d = req_seen_q;
    wden_d     = wden_q;
    wdlive_d   = wdlive_q;
    wtocnt_d   = wtocnt_q;
    rvalid_d   = '0;
    ack_d      = ack_q;
    bad_d      = bad_q;
    if (state_q == ST_IDLE && new_req) begin
      req_seen_d = sync_out;
      if (src_addr_i == ADDR_WDEN) begin
        wden_d   = src_wdata_i[0];
        rvalid_d = 3'b100;
      end else if (src_addr_i == ADDR_WDLIVE) begin
        wdlive_d = src_wdata_i[0];
        rvalid_d = 3'b010;
      end else if (src_addr_i == ADDR_WTOCNT) begin
        wtocnt_d = src_wdata_i;
        rvalid_d = 3'b001;
      end else begin
        bad_d = 1'b1;
      end
    end
    if (state_q == ST_ISSUE) ack_d = ~ack_q;
  end

  assign dst_ack_tog_o = ack_q;
  assign WDEN          = wden_q;
  assign WDLIVE        = wdlive_q;
  assign WTOCNT        = wtocnt_q;
  assign WDEN_RVALID   = rvalid_q[2];
  assign WDLIVE_RVALID = rvalid_q[1];
  assign WTOCNT_RVALID = rvalid_q[0];
  assign bad_addr_o    = bad_q;

endmodule

// File: tb/tb_wdt_reg_sync_rx.sv
// Randomized bench for wdt_reg_sync_rx against a register-level model of the watchdog
// write bridge (values, sticky bad flag, ack count, strobe timing).
module tb_wdt_reg_sync_rx;

  localparam int SYNC = 2;

  logic        clk2 = 1'b0;
  logic        rst2 = 1'b1;
  logic        src_req_tog_i = 1'b0;
  logic [15:0] src_addr_i = '0;
  logic [31:0] src_wdata_i = '0;
  logic        dst_ack_tog_o;
  logic        WDEN, WDLIVE;
  logic [31:0] WTOCNT;
  logic        WDEN_RVALID, WDLIVE_RVALID, WTOCNT_RVALID;
  logic        bad_addr_o;

  int n_chk = 0;
  int n_err = 0;

  logic        m_wden, m_wdlive, m_bad, m_ack;
  logic [31:0] m_wtocnt;

  wdt_reg_sync_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk2(clk2), .rst2(rst2), .src_req_tog_i(src_req_tog_i), .src_addr_i(src_addr_i),
    .src_wdata_i(src_wdata_i), .dst_ack_tog_o(dst_ack_tog_o), .WDEN(WDEN), .WDLIVE(WDLIVE),
    .WTOCNT(WTOCNT), .WDEN_RVALID(WDEN_RVALID), .WDLIVE_RVALID(WDLIVE_RVALID),
    .WTOCNT_RVALID(WTOCNT_RVALID), .bad_addr_o(bad_addr_o)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] strobes();
    return {WDEN_RVALID, WDLIVE_RVALID, WTOCNT_RVALID};
  endfunction

  task automatic model_reset();
    m_wden = 0; m_wdlive = 0; m_wtocnt = 0; m_bad = 0; m_ack = 0;
  endtask

  task automatic check_values(input string tag);
    check({tag, "_wden"},   {31'd0, WDEN},       {31'd0, m_wden});
    check({tag, "_wdlive"}, {31'd0, WDLIVE},     {31'd0, m_wdlive});
    check({tag, "_wtocnt"}, WTOCNT,              m_wtocnt);
    check({tag, "_bad"},    {31'd0, bad_addr_o}, {31'd0, m_bad});
  endtask

  // One write: strobe appears SYNC+1 edges after the toggle, ack one edge after that.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data);
    logic [2:0] exp_rv;
    @(negedge clk2);
    src_addr_i    = addr;
    src_wdata_i   = data;
    src_req_tog_i = ~src_req_tog_i;
    exp_rv = 3'b000;
    case (addr)
      16'h0100: begin m_wden   = data[0]; exp_rv = 3'b100; end
      16'h0200: begin m_wdlive = data[0]; exp_rv = 3'b010; end
      16'h0300: begin m_wtocnt = data;    exp_rv = 3'b001; end
      default:  m_bad = 1'b1;
    endcase
    for (int e = 1; e <= SYNC + 3; e++) begin
      @(posedge clk2); #1;
      if (e <= SYNC) begin
        check("early_strobe", {29'd0, strobes()}, 32'd0);
      end else if (e == SYNC + 1) begin
        check("strobe", {29'd0, strobes()}, {29'd0, exp_rv});
        check("ack_before", {31'd0, dst_ack_tog_o}, {31'd0, m_ack});
        check_values("val");
        m_ack = ~m_ack;
      end else if (e == SYNC + 2) begin
        check("strobe_clr", {29'd0, strobes()}, 32'd0);
        check("ack_after", {31'd0, dst_ack_tog_o}, {31'd0, m_ack});
      end else begin
        check("idle_strobe", {29'd0, strobes()}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [15:0] a;
    logic [31:0] d;
    model_reset();

    // Reset held while the request toggles: nothing may come out.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk2);
      src_req_tog_i = ~src_req_tog_i;
      @(posedge clk2); #1;
      check("rst_strobe", {29'd0, strobes()}, 32'd0);
      check("rst_ack", {31'd0, dst_ack_tog_o}, 32'd0);
    end
    check_values("rst");
    @(negedge clk2);
    src_req_tog_i = 1'b0;
    rst2 = 1'b0;

    do_write(16'h0300, 32'hDEAD_BEEF);
    do_write(16'h0100, 32'h0000_0001);
    do_write(16'h0200, 32'h0000_0003);
    check_values("wden_kept");
    do_write(16'h0104, 32'hFFFF_FFFF);
    do_write(16'h0200, 32'h0000_0000);
    check("bad_sticky", {31'd0, bad_addr_o}, 32'd1);

    // Reset while the strobe is up (ISSUE): strobe drops at once, no ack.
    @(negedge clk2);
    src_addr_i = 16'h0300;
    src_wdata_i = 32'h1234_5678;
    src_req_tog_i = ~src_req_tog_i;
    for (int e = 1; e <= SYNC + 1; e++) begin @(posedge clk2); #1; end
    check("pre_rst_strobe", {29'd0, strobes()}, 32'd1);
    #2 rst2 = 1'b1;
    #1;
    model_reset();
    src_req_tog_i = 1'b0;
    check("rst_issue_strobe", {29'd0, strobes()}, 32'd0);
    check("rst_issue_ack", {31'd0, dst_ack_tog_o}, 32'd0);
    check_values("rst_issue");
    @(negedge clk2);
    rst2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk2); #1;
      check("post_rst_strobe", {29'd0, strobes()}, 32'd0);
      check("post_rst_ack", {31'd0, dst_ack_tog_o}, 32'd0);
    end
    do_write(16'h0100, 32'h0000_0001);

    // Glitch pair between edges: the synchroniser never sees it.
    @(negedge clk2);
    src_req_tog_i = ~src_req_tog_i;
    #1 src_req_tog_i = ~src_req_tog_i;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk2); #1;
      check("glitch_strobe", {29'd0, strobes()}, 32'd0);
      check("glitch_ack", {31'd0, dst_ack_tog_o}, {31'd0, m_ack});
    end

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: a = 16'h0100;
        1: a = 16'h0200;
        2: a = 16'h0300;
        3: a = 16'h0104;
        default: a = 16'($urandom);
      endcase
      d = $urandom;
      do_write(a, d);
    end
    check_values("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
